// File: rtl/gru_matvec_sched_pkg.sv
// Shared types and constants for the GRU mat-vec scheduler.
package gru_matvec_sched_pkg;

    localparam int unsigned X          = 4;
    localparam int unsigned H          = 4;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned NUM_OPS    = 6;
    localparam int unsigned OP_W       = 3;

    localparam int unsigned VEC_W = X * DATA_WIDTH;
    localparam int unsigned MAT_W = X * H * DATA_WIDTH;
    localparam int unsigned RES_W = H * DATA_WIDTH;

    // Gate product order: even ops use x, odd ops use h.
    localparam logic [OP_W-1:0] OP_WZ = 3'd0;
    localparam logic [OP_W-1:0] OP_UZ = 3'd1;
    localparam logic [OP_W-1:0] OP_WR = 3'd2;
    localparam logic [OP_W-1:0] OP_UR = 3'd3;
    localparam logic [OP_W-1:0] OP_WH = 3'd4;
    localparam logic [OP_W-1:0] OP_UH = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_MUL   = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/gru_matvec_sched.sv
// Time-multiplexes one shared mat-vec multiplier across the six GRU gate
// products, fetching weights from ROM and streaming results on valid/ready.
module gru_matvec_sched
    import gru_matvec_sched_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [VEC_W-1:0] x_vec_i,
    input  logic [VEC_W-1:0] h_vec_i,
    output logic             w_rd_o,
    output logic [OP_W-1:0]  w_addr_o,
    input  logic [MAT_W-1:0] w_data_i,
    output logic [MAT_W-1:0] mult_a_o,
    output logic [VEC_W-1:0] mult_b_o,
    input  logic [RES_W-1:0] mult_c_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [RES_W-1:0] res_data_o,
    output logic [OP_W-1:0]  res_op_o,
    output logic             busy_o,
    output logic             done_o
);

    state_e           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [VEC_W-1:0] x_q, x_d;
    logic [VEC_W-1:0] h_q, h_d;
    logic [MAT_W-1:0] a_q, a_d;
    logic [VEC_W-1:0] b_q, b_d;
    logic [RES_W-1:0] res_data_q, res_data_d;
    logic [OP_W-1:0]  res_op_q, res_op_d;
    logic             w_rd_q, w_rd_d;
    logic [OP_W-1:0]  w_addr_q, w_addr_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // State, operand, result and registered-output update; reset drops any in-flight ROM data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            x_q         <= '0;
            h_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            w_rd_q      <= 1'b0;
            w_addr_q    <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            x_q         <= x_d;
            h_q         <= h_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            w_rd_q      <= w_rd_d;
            w_addr_q    <= w_addr_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they are registered yet cycle-aligned with the state.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        x_d        = x_q;
        h_d        = h_q;
        a_d        = a_q;
        res_data_d = res_data_q;
        res_op_d   = res_op_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    x_d     = x_vec_i;
                    h_d     = h_vec_i;
                    op_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                a_d     = w_data_i;
                state_d = S_MUL;
            end
            S_MUL: begin
                res_data_d = mult_c_i;
                res_op_d   = op_q;
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (res_valid_q && res_ready_i) begin
                    if (op_q == OP_W'(NUM_OPS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        op_d    = op_q + OP_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        w_rd_d      = (state_d == S_FETCH);
        w_addr_d    = (state_d == S_FETCH) ? op_d : '0;
        res_valid_d = (state_d == S_OUT);
        busy_d      = (state_d == S_FETCH) || (state_d == S_LOAD) ||
                      (state_d == S_MUL)   || (state_d == S_OUT);
        done_d      = (state_d == S_DONE);
        b_d         = op_d[0] ? h_d : x_d;
    end

    assign w_rd_o      = w_rd_q;
    assign w_addr_o    = w_addr_q;
    assign mult_a_o    = a_q;
    assign mult_b_o    = b_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_op_o    = res_op_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_gru_matvec_sched.sv
// Bench for gru_matvec_sched with behavioural ROM and multiplier models.
module tb_gru_matvec_sched;
    import gru_matvec_sched_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [VEC_W-1:0] x_vec, h_vec;
    logic             w_rd;
    logic [OP_W-1:0]  w_addr;
    logic [MAT_W-1:0] w_data;
    logic [MAT_W-1:0] mult_a;
    logic [VEC_W-1:0] mult_b;
    logic [RES_W-1:0] mult_c;
    logic             res_valid, res_ready;
    logic [RES_W-1:0] res_data;
    logic [OP_W-1:0]  res_op;
    logic             busy, done;

    int checks = 0;
    int errors = 0;

    logic [MAT_W-1:0] rom     [NUM_OPS];
    logic [RES_W-1:0] exp_res [NUM_OPS];

    always #5 clk = ~clk;

    gru_matvec_sched dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .x_vec_i     (x_vec),
        .h_vec_i     (h_vec),
        .w_rd_o      (w_rd),
        .w_addr_o    (w_addr),
        .w_data_i    (w_data),
        .mult_a_o    (mult_a),
        .mult_b_o    (mult_b),
        .mult_c_i    (mult_c),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .res_op_o    (res_op),
        .busy_o      (busy),
        .done_o      (done)
    );

    // Q4.4 signed mat-vec: row i = (sum_j a[i][j]*b[j]) >>> 4, truncated.
    function automatic logic [RES_W-1:0] matvec(input logic [MAT_W-1:0] a, input logic [VEC_W-1:0] b);
        logic [RES_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(H); i++) begin
            int acc;
            acc = 0;
            for (int j = 0; j < int'(X); j++) begin
                logic signed [DATA_WIDTH-1:0] ae, be;
                ae = a[(i*X+j)*DATA_WIDTH +: DATA_WIDTH];
                be = b[j*DATA_WIDTH +: DATA_WIDTH];
                acc += int'(ae) * int'(be);
            end
            r[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(acc >>> 4);
        end
        return r;
    endfunction

    // Behavioural multiplier: combinational from operands.
    always_comb mult_c = matvec(mult_a, mult_b);

    // Behavioural ROM: data valid one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        if (w_rd && (w_addr < OP_W'(NUM_OPS)))
            w_data <= rom[w_addr];
        else
            w_data <= {$urandom, $urandom, $urandom, $urandom};
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_w_rd"}, 128'(w_rd), 128'(0));
        chk({tag, "_w_addr"}, 128'(w_addr), 128'(0));
        chk({tag, "_mult_a"}, 128'(mult_a), 128'(0));
        chk({tag, "_mult_b"}, 128'(mult_b), 128'(0));
        chk({tag, "_res_valid"}, 128'(res_valid), 128'(0));
        chk({tag, "_res_data"}, 128'(res_data), 128'(0));
        chk({tag, "_res_op"}, 128'(res_op), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
    endtask

    task automatic fill_rom_random();
        for (int k = 0; k < int'(NUM_OPS); k++)
            rom[k] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One run from a start pulse; op stall_op is held in OUT for stall extra cycles.
    // disturb: change x_vec in cycle 2, pulse start in cycle 6 and during DONE.
    task automatic do_run(input string name, input int stall_op, input int stall, input bit disturb);
        logic [VEC_W-1:0] xs, hs;
        int last;
        xs = x_vec;
        hs = h_vec;
        for (int k = 0; k < int'(NUM_OPS); k++)
            exp_res[k] = matvec(rom[k], (k % 2 == 1) ? hs : xs);
        last = 27 + stall;

        @(negedge clk);
        start     = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= last; c++) begin
            bit exp_wrd, exp_val;
            int wk, vk, vs_k;
            @(negedge clk);
            exp_wrd = 1'b0;
            exp_val = 1'b0;
            wk = 0;
            vk = 0;
            vs_k = 0;
            for (int k = 0; k < int'(NUM_OPS); k++) begin
                int sh, vs, ve;
                sh = (k > stall_op) ? stall : 0;
                vs = 4 + 4*k + sh;
                ve = vs + ((k == stall_op) ? stall : 0);
                if (c == 1 + 4*k + sh) begin
                    exp_wrd = 1'b1;
                    wk = k;
                end
                if (c >= vs && c <= ve) begin
                    exp_val = 1'b1;
                    vk = k;
                    vs_k = vs;
                end
            end
            res_ready = !(exp_val && vk == stall_op && c < vs_k + stall);
            start     = disturb && (c == 6 || c == 25 + stall);
            if (disturb && c == 2)
                x_vec = $urandom;

            chk($sformatf("%s_w_rd_c%0d", name, c), 128'(w_rd), 128'(exp_wrd));
            chk($sformatf("%s_res_valid_c%0d", name, c), 128'(res_valid), 128'(exp_val));
            chk($sformatf("%s_done_c%0d", name, c), 128'(done), 128'(c == 25 + stall));
            chk($sformatf("%s_busy_c%0d", name, c), 128'(busy), 128'(c <= 24 + stall));
            if (exp_wrd)
                chk($sformatf("%s_w_addr_c%0d", name, c), 128'(w_addr), 128'(wk));
            if (exp_val) begin
                chk($sformatf("%s_res_data_op%0d_c%0d", name, vk, c), 128'(res_data), 128'(exp_res[vk]));
                chk($sformatf("%s_res_op_c%0d", name, c), 128'(res_op), 128'(vk));
            end
        end
        start     = 1'b0;
        res_ready = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        x_vec     = '0;
        h_vec     = '0;
        res_ready = 1'b1;
        fill_rom_random();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_initial");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset held two cycles while idle.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset_idle");
        rst = 1'b0;
        @(negedge clk);

        // Identity weights: even ops return x, odd ops return h.
        for (int k = 0; k < int'(NUM_OPS); k++) begin
            rom[k] = '0;
            for (int i = 0; i < int'(H); i++)
                rom[k][(i*X+i)*DATA_WIDTH +: DATA_WIDTH] = 8'h10;
        end
        x_vec = 32'h40302010;
        h_vec = 32'h38281808;
        do_run("identity", 99, 0, 1'b0);

        // Packing: all-0x10 weights, x all 0x10, h all 0x00.
        for (int k = 0; k < int'(NUM_OPS); k++)
            rom[k] = {16{8'h10}};
        x_vec = 32'h10101010;
        h_vec = 32'h00000000;
        do_run("packing", 99, 0, 1'b0);

        // Backpressure on op 2 for three cycles.
        fill_rom_random();
        x_vec = $urandom;
        h_vec = $urandom;
        do_run("stall", 2, 3, 1'b0);

        // Ignored starts and input isolation.
        fill_rom_random();
        x_vec = $urandom;
        h_vec = $urandom;
        do_run("isolate", 99, 0, 1'b1);

        // Mid-run reset in cycle 10, then a fresh run.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 10) rst = 1'b1;
        end
        @(negedge clk);
        chk_all_zero("midrun_reset");
        rst = 1'b0;
        fill_rom_random();
        x_vec = $urandom;
        h_vec = $urandom;
        do_run("after_reset", 99, 0, 1'b0);

        // A few randomised runs with random stall placement.
        for (int r = 0; r < 3; r++) begin
            fill_rom_random();
            x_vec = $urandom;
            h_vec = $urandom;
            do_run($sformatf("rand%0d", r), int'($urandom_range(0, NUM_OPS - 1)),
                   int'($urandom_range(0, 4)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
